ps2_keycode_port: RTL and testbench

PS2_KEYCODE_PORT -- requirements
Module: ps2_keycode_port

---
 rtl/ps2_keycode_port.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ps2_keycode_port.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_port.sv
// ps2_keycode_port
// Receives PS/2 keyboard frames, decodes scan code set 2 make codes (US layout)
// into 7-bit ASCII and queues them for a consumer.
//
// Ports
//   clk        system clock, all state on its rising edge
//   reset      asynchronous, active-high reset
//   ps2_clk    raw PS/2 clock line (asynchronous)
//   ps2_data   raw PS/2 data line (asynchronous)
//   keycode    {valid, ascii[6:0]} of the queue head, 8'h00 when empty
//   keystrobe  consumer acknowledge; pops the head while high and valid
//   frame_err  one-cycle pulse when a frame is rejected (parity/stop/timeout)
//   overflow   one-cycle pulse when a decoded key is dropped on a full queue
module ps2_keycode_port #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    input  logic       keystrobe,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Scan code -> {hit, ascii}. hit = 0 means the code is not translated.
    function automatic logic [7:0] xlate(input logic [7:0] code, input logic ext);
        logic [7:0] r;
        r = 8'h00;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, 7'h77};
                8'h72:   r = {1'b1, 7'h73};
                8'h6B:   r = {1'b1, 7'h61};
                8'h74:   r = {1'b1, 7'h64};
                default: r = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: r = {1'b1, 7'h61};  8'h32: r = {1'b1, 7'h62};
                8'h21: r = {1'b1, 7'h63};  8'h23: r = {1'b1, 7'h64};
                8'h24: r = {1'b1, 7'h65};  8'h2B: r = {1'b1, 7'h66};
                8'h34: r = {1'b1, 7'h67};  8'h33: r = {1'b1, 7'h68};
                8'h43: r = {1'b1, 7'h69};  8'h3B: r = {1'b1, 7'h6A};
                8'h42: r = {1'b1, 7'h6B};  8'h4B: r = {1'b1, 7'h6C};
                8'h3A: r = {1'b1, 7'h6D};  8'h31: r = {1'b1, 7'h6E};
                8'h44: r = {1'b1, 7'h6F};  8'h4D: r = {1'b1, 7'h70};
                8'h15: r = {1'b1, 7'h71};  8'h2D: r = {1'b1, 7'h72};
                8'h1B: r = {1'b1, 7'h73};  8'h2C: r = {1'b1, 7'h74};
                8'h3C: r = {1'b1, 7'h75};  8'h2A: r = {1'b1, 7'h76};
                8'h1D: r = {1'b1, 7'h77};  8'h22: r = {1'b1, 7'h78};
                8'h35: r = {1'b1, 7'h79};  8'h1A: r = {1'b1, 7'h7A};
                8'h45: r = {1'b1, 7'h30};  8'h16: r = {1'b1, 7'h31};
                8'h1E: r = {1'b1, 7'h32};  8'h26: r = {1'b1, 7'h33};
                8'h25: r = {1'b1, 7'h34};  8'h2E: r = {1'b1, 7'h35};
                8'h36: r = {1'b1, 7'h36};  8'h3D: r = {1'b1, 7'h37};
                8'h3E: r = {1'b1, 7'h38};  8'h46: r = {1'b1, 7'h39};
                8'h29: r = {1'b1, 7'h20};  8'h5A: r = {1'b1, 7'h0D};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // ---------------- synchronizers and clock filter ----------------
    logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic          filt_r, filt_prev_r;
    logic [FW-1:0] filt_cnt_r;
    logic          fall_s;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_data;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Glitch filter: the accepted ps2_clk level flips after FILTER_LEN
    // consecutive samples that disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_r      <= 1'b1;
            filt_prev_r <= 1'b1;
            filt_cnt_r  <= '0;
        end else begin
            filt_prev_r <= filt_r;
            if (clk_sync_r == filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FILT_MAX) begin
                filt_r     <= clk_sync_r;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end
    end

    assign fall_s = filt_prev_r & ~filt_r;

    // ---------------- receiver FSM ----------------
    rx_state_t     state_r, state_s;
    logic [7:0]    shift_r, shift_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic          parity_r, parity_s;
    logic [TW-1:0] tmo_cnt_r;
    logic          accept_s, reject_s;
    logic [7:0]    rx_byte_r;
    logic          rx_valid_r;

    // Next-state logic: advances one bit per filtered falling edge; a stalled
    // partial frame is abandoned when the timeout counter saturates.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        parity_s  = parity_r;
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!dat_sync_r) begin
                        state_s   = DATA;
                        bit_cnt_s = 3'd0;
                        shift_s   = 8'h00;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s   = {dat_sync_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    parity_s = dat_sync_r;
                    state_s  = STOP;
                end
                STOP: begin
                    state_s = IDLE;
                    if ((^{shift_r, parity_r}) && dat_sync_r) begin
                        accept_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end
                default: state_s = IDLE;
            endcase
        end else if ((state_r != IDLE) && (tmo_cnt_r == TMO_MAX)) begin
            state_s  = IDLE;
            reject_s = 1'b1;
        end else begin
            state_s = state_r;
        end
    end

    // Receiver state, inter-edge timeout counter and accepted-byte register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            parity_r   <= 1'b0;
            tmo_cnt_r  <= '0;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            parity_r   <= parity_s;
            rx_valid_r <= accept_s;
            frame_err  <= reject_s;
            if (accept_s) begin
                rx_byte_r <= shift_r;
            end
            if ((state_r == IDLE) || fall_s) begin
                tmo_cnt_r <= '0;
            end else if (tmo_cnt_r != TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    // ---------------- decoder ----------------
    logic       brk_r, ext_r, brk_s, ext_s;
    logic       push_s;
    logic [7:0] xl_s;

    assign xl_s = xlate(rx_byte_r, ext_r);

    // Prefix handling: F0 marks a break (release), E0 selects the extended
    // table; any other byte consumes both flags.
    always_comb begin
        brk_s  = brk_r;
        ext_s  = ext_r;
        push_s = 1'b0;
        if (rx_valid_r) begin
            if (rx_byte_r == 8'hF0) begin
                brk_s = 1'b1;
            end else if (rx_byte_r == 8'hE0) begin
                ext_s = 1'b1;
            end else begin
                brk_s  = 1'b0;
                ext_s  = 1'b0;
                push_s = ~brk_r & xl_s[7];
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // ---------------- keycode queue ----------------
    logic [6:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [AW:0]   count_r, count_s;
    logic          pop_s, full_s, wr_en_s;
    logic [7:0]    head_s;

    assign pop_s     = (count_r != '0) & keystrobe;
    assign full_s    = (count_r == FULL_CNT);
    assign wr_en_s   = push_s & (~full_s | pop_s);
    assign rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    assign count_s   = count_r + (AW + 1)'(wr_en_s) - (AW + 1)'(pop_s);

    // Next head value, so keycode is a register: the slot being written this
    // cycle is bypassed from the decoder.
    always_comb begin
        if (count_s == '0) begin
            head_s = 8'h00;
        end else if (wr_en_s && (rd_next_s == wr_ptr_r)) begin
            head_s = {1'b1, xl_s[6:0]};
        end else begin
            head_s = {1'b1, mem_r[rd_next_s]};
        end
    end

    // Decoder flags, queue storage/pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_r    <= 1'b0;
            ext_r    <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            keycode  <= 8'h00;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 7'h00;
            end
        end else begin
            brk_r    <= brk_s;
            ext_r    <= ext_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_s;
            keycode  <= head_s;
            overflow <= push_s & full_s & ~pop_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= xl_s[6:0];
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_port.sv
module tb_ps2_keycode_port;

    localparam int FL    = 8;
    localparam int TMO   = 400;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    localparam logic [7:0] SC_ALPHA [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] SC_DIGIT [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] SC_EXT [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [7:0] ASC_EXT [4] = '{8'h77, 8'h73, 8'h61, 8'h64};

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       keystrobe;
    logic       frame_err;
    logic       overflow;

    int n_vec = 0;
    int n_bad = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [6:0] mq[$];
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;

    always #5 clk = ~clk;

    ps2_keycode_port #(.FILTER_LEN(FL), .TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .keystrobe(keystrobe),
        .frame_err(frame_err), .overflow(overflow));

    // Pulse counters on the inactive edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (frame_err) fe_seen++;
            if (overflow) ov_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference translation: ASCII value or -1 when untranslated.
    function automatic int ref_xlate(input logic [7:0] code, input bit ext);
        if (ext) begin
            for (int i = 0; i < 4; i++) if (SC_EXT[i] == code) return int'(ASC_EXT[i]);
            return -1;
        end
        for (int i = 0; i < 26; i++) if (SC_ALPHA[i] == code) return 97 + i;
        for (int i = 0; i < 10; i++) if (SC_DIGIT[i] == code) return 48 + i;
        if (code == 8'h29) return 32;
        if (code == 8'h5A) return 13;
        return -1;
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit ok);
        int a;
        if (!ok) begin
            exp_fe++;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (!m_brk) begin
                a = ref_xlate(d, m_ext);
                if (a >= 0) begin
                    if (mq.size() == DEPTH) exp_ov++;
                    else mq.push_back(a[6:0]);
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // Drives nbits LSB-first PS/2 bits, all transitions on a negedge.
    // On the 11th bit's low phase: optional latency check or keystrobe pulse.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int ks_at, input int lat_exp);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && lat_exp >= 0) begin
                repeat (FL + 3) @(negedge clk);
                check("latency_pre", {31'd0, keycode[7]}, 32'd0);
                @(negedge clk);
                check("latency_at", {24'd0, keycode}, lat_exp);
                repeat (HALF - FL - 4) @(negedge clk);
            end else if (i == 10 && ks_at >= 0) begin
                repeat (ks_at) @(negedge clk);
                keystrobe = 1'b1;
                @(negedge clk);
                keystrobe = 1'b0;
                repeat (HALF - ks_at - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                            input int ks_at, input int lat_exp);
        logic p;
        p = par_ok ? ~(^d) : (^d);
        send_bits({stop_ok, p, d, 1'b0}, 11, ks_at, lat_exp);
        model_frame(d, par_ok && stop_ok);
        repeat (8) @(negedge clk);
        check("frame_err_count", fe_seen, exp_fe);
        check("overflow_count", ov_seen, exp_ov);
    endtask

    task automatic key(input logic [7:0] d);
        send_key(d, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic drain();
        while (mq.size() > 0) begin
            check("queue_head", {24'd0, keycode}, {24'd0, 1'b1, mq[0]});
            keystrobe = 1'b1;
            void'(mq.pop_front());
            @(negedge clk);
        end
        check("drain_empty", {24'd0, keycode}, 32'd0);
        @(negedge clk);
        keystrobe = 1'b0;
        check("strobe_on_empty", {24'd0, keycode}, 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        int fe0;
        logic [7:0] d;
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        keystrobe = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_keycode", {24'd0, keycode}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single make code, exact latency, then pop.
        send_key(8'h1D, 1'b1, 1'b1, -1, 8'hF7);
        check("hold_without_strobe", {24'd0, keycode}, 32'hF7);
        drain();

        // Break sequence suppresses the key.
        key(8'hF0);
        key(8'h1D);
        check("break_suppressed", {24'd0, keycode}, 32'd0);
        key(8'h1C);
        drain();

        // Extended codes.
        key(8'hE0); key(8'h6B);
        key(8'hE0); key(8'h74);
        key(8'hE0); key(8'h10);
        drain();

        // Parity error.
        send_key(8'h1C, 1'b0, 1'b1, -1, -1);
        check("parity_err_keycode", {24'd0, keycode}, 32'd0);
        // Stop error.
        send_key(8'h1C, 1'b1, 1'b0, -1, -1);
        check("stop_err_keycode", {24'd0, keycode}, 32'd0);

        // Partial frame then silence: timeout.
        fe0 = fe_seen;
        send_bits(11'h000, 4, -1, -1);
        repeat (TMO - 30) @(negedge clk);
        check("no_early_timeout", fe_seen, fe0);
        repeat (60) @(negedge clk);
        exp_fe++;
        check("timeout_frame_err", fe_seen, exp_fe);
        key(8'h1C);
        drain();

        // Overflow on fifth key, then drain on consecutive cycles.
        key(8'h1D); key(8'h1B); key(8'h1C); key(8'h23); key(8'h29);
        drain();

        // Full queue: push and pop in the same cycle, no overflow.
        key(8'h1C); key(8'h1B); key(8'h23); key(8'h29);
        void'(mq.pop_front());
        send_key(8'h1D, 1'b1, 1'b1, FL + 3, -1);
        drain();

        // Reset mid-frame with a key already queued.
        key(8'h1D);
        send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 5, -1, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_keycode", {24'd0, keycode}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        mq.delete();
        m_brk = 1'b0;
        m_ext = 1'b0;
        @(negedge clk);
        check("after_reset_keycode", {24'd0, keycode}, 32'd0);
        send_key(8'h23, 1'b1, 1'b1, -1, 8'hE4);
        drain();

        // Randomized frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) d = 8'hF0;
            else if (r == 1) d = 8'hE0;
            else if (r <= 4) d = SC_ALPHA[$urandom_range(0, 25)];
            else if (r == 5) d = SC_DIGIT[$urandom_range(0, 9)];
            else if (r == 6) d = SC_EXT[$urandom_range(0, 3)];
            else d = 8'($urandom_range(0, 255));
            send_key(d, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0, -1, -1);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
